// File: rtl/quad_pkg.sv
// quad_pkg: quadrature state/move types and the Gray-sequence move decoder
package quad_pkg;
  typedef enum logic [1:0] {Q00 = 2'b00, Q01 = 2'b01, Q11 = 2'b11, Q10 = 2'b10} quad_state_t;
  typedef enum logic [1:0] {MV_NONE, MV_UP, MV_DOWN, MV_ILLEGAL} quad_move_t;
  function automatic quad_move_t decode_move(quad_state_t prev, quad_state_t curr);
    logic [1:0] fwd;
    fwd = {prev[0], ~prev[1]};
    return prev == curr ? MV_NONE : (prev ^ curr) == 2'b11 ? MV_ILLEGAL : curr == fwd ? MV_UP : MV_DOWN;
  endfunction
endpackage

// File: rtl/phase_filter.sv
// phase_filter: synchronizer plus FILT-cycle debounce for one quadrature phase
module phase_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic stable
);
  localparam int CW = $clog2(FILT + 1);
  logic [SYNC_STAGES-1:0] sync, fill;
  logic [CW-1:0] dcnt, scnt;
  logic s, v;
  assign s = sync[SYNC_STAGES-1];
  // fill marks when the last stage holds a real sample rather than its reset value
  assign v = fill[SYNC_STAGES-1];
  assign stable = scnt == CW'(FILT);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync <= '0;
      fill <= '0;
      dcnt <= '0;
      scnt <= '0;
      out  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in};
      fill <= {fill[SYNC_STAGES-2:0], 1'b1};
      dcnt <= (v && s != out && dcnt != CW'(FILT - 1)) ? dcnt + 1'b1 : '0;
      if (v && s != out && dcnt == CW'(FILT - 1)) out <= s;
      scnt <= (v && s == out) ? (stable ? scnt : scnt + 1'b1) : '0;
    end
endmodule

// File: rtl/quadrature_decoder.sv
// quadrature_decoder: filtered A/B quadrature to step/direction pulses and a loadable position
module quadrature_decoder import quad_pkg::*; #(
  parameter int NBITS = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic             load,
  input  logic [NBITS-1:0] d,
  input  logic             err_clr,
  output logic             step,
  output logic             up_down,
  output logic [NBITS-1:0] pos,
  output logic [NBITS-1:0] posn,
  output logic             err
);
  logic a_lvl, b_lvl, a_st, b_st, primed, mv_step;
  quad_state_t prev, curr;
  quad_move_t mv;
  phase_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT(FILT)) u_a (
    .clk(clk), .reset(reset), .in(a), .out(a_lvl), .stable(a_st)
  );
  phase_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT(FILT)) u_b (
    .clk(clk), .reset(reset), .in(b), .out(b_lvl), .stable(b_st)
  );
  assign curr = quad_state_t'({a_lvl, b_lvl});
  assign mv = primed ? decode_move(prev, curr) : MV_NONE;
  assign mv_step = mv == MV_UP || mv == MV_DOWN;
  assign posn = ~pos;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      step    <= 1'b0;
      up_down <= 1'b1;
      pos     <= '0;
      err     <= 1'b0;
      primed  <= 1'b0;
      prev    <= Q00;
    end else begin
      step <= mv_step;
      if (mv_step) up_down <= mv == MV_UP;
      pos  <= load ? d : mv == MV_UP ? pos + 1'b1 : mv == MV_DOWN ? pos - 1'b1 : pos;
      err  <= mv == MV_ILLEGAL || (err && !err_clr);
      if (a_st && b_st) primed <= 1'b1;
      if (primed || (a_st && b_st)) prev <= curr;
    end
endmodule

// File: tb/tb_quadrature_decoder.sv
// tb_quadrature_decoder: directed scoreboard bench for quadrature_decoder
module tb_quadrature_decoder;
  logic clk = 1'b0, reset = 1'b1, a = 1'b0, b = 1'b0, load = 1'b0, err_clr = 1'b0;
  logic [3:0] d = 4'h0;
  logic step, up_down, err;
  logic [3:0] pos, posn;
  int checks = 0, failures = 0, cyc = 0, exp_pos = 0;
  typedef struct {int cyc; logic ud; logic [3:0] pos;} exp_t;
  exp_t q[$];

  quadrature_decoder dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .load(load), .d(d), .err_clr(err_clr),
    .step(step), .up_down(up_down), .pos(pos), .posn(posn), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_wait(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic move(logic [1:0] ab, logic ud, int dpos);
    {a, b} = ab;
    exp_pos = (exp_pos + dpos) & 15;
    q.push_back('{cyc + 5, ud, 4'(exp_pos)});
  endtask

  always @(negedge clk)
    if (!reset) begin
      if (q.size() != 0 && q[0].cyc < cyc) begin
        chk("step_missing_at", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (step) begin
        chk("step_expected", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          chk("step_cyc", cyc, q[0].cyc);
          chk("step_dir", up_down, q[0].ud);
          chk("step_pos", pos, q[0].pos);
          chk("step_posn", posn, 4'(~q[0].pos));
          void'(q.pop_front());
        end
      end
    end

  initial begin
    cyc_wait(3);
    chk("rst_step", step, 0);
    chk("rst_up_down", up_down, 1);
    chk("rst_pos", pos, 0);
    chk("rst_posn", posn, 4'hF);
    chk("rst_err", err, 0);
    reset = 1'b0;
    cyc_wait(10);
    chk("prime_pos", pos, 0);
    chk("prime_posn", posn, 4'hF);
    chk("prime_err", err, 0);
    chk("prime_step", step, 0);
    // forward lap
    move(2'b01, 1, 1); cyc_wait(8);
    move(2'b11, 1, 1); cyc_wait(8);
    move(2'b10, 1, 1); cyc_wait(8);
    move(2'b00, 1, 1); cyc_wait(8);
    chk("fwd_pos", pos, 4);
    chk("fwd_up_down", up_down, 1);
    // reverse from zero wraps to all ones
    load = 1'b1; d = 4'h0; cyc_wait(1); load = 1'b0; exp_pos = 0;
    chk("load0_pos", pos, 0);
    move(2'b10, 0, -1); cyc_wait(8);
    chk("rev_pos", pos, 4'hF);
    chk("rev_up_down", up_down, 0);
    chk("rev_hold_step", step, 0);
    // load in the same cycle as a step wins the position
    {a, b} = 2'b00; exp_pos = 7; q.push_back('{cyc + 5, 1'b1, 4'h7});
    cyc_wait(4); load = 1'b1; d = 4'h7;
    cyc_wait(1); load = 1'b0;
    cyc_wait(8);
    chk("load_step_pos", pos, 7);
    // short glitches are discarded
    a = 1'b1; cyc_wait(1); a = 1'b0; cyc_wait(10);
    b = 1'b1; cyc_wait(1); b = 1'b0; cyc_wait(10);
    chk("glitch_pos", pos, 7);
    chk("glitch_err", err, 0);
    // illegal jumps and sticky error
    {a, b} = 2'b11; cyc_wait(8);
    chk("illegal_err", err, 1);
    chk("illegal_pos", pos, 7);
    {a, b} = 2'b00; cyc_wait(4); err_clr = 1'b1;
    cyc_wait(1); err_clr = 1'b0;
    chk("set_wins_err", err, 1);
    chk("illegal2_pos", pos, 7);
    cyc_wait(3);
    err_clr = 1'b1; cyc_wait(1); err_clr = 1'b0;
    chk("clr_err", err, 0);
    // reach pos=3 with err set, then reset asynchronously
    load = 1'b1; d = 4'h2; cyc_wait(1); load = 1'b0; exp_pos = 2;
    move(2'b01, 1, 1); cyc_wait(8);
    chk("pre_rst_pos", pos, 3);
    {a, b} = 2'b10; cyc_wait(8);
    chk("pre_rst_err", err, 1);
    #2 reset = 1'b1; {a, b} = 2'b11;
    #1;
    chk("async_pos", pos, 0);
    chk("async_err", err, 0);
    chk("async_up_down", up_down, 1);
    cyc_wait(3);
    reset = 1'b0; exp_pos = 0;
    cyc_wait(15);
    chk("reprime_err", err, 0);
    chk("reprime_pos", pos, 0);
    move(2'b10, 1, 1); cyc_wait(8);
    chk("post_rst_pos", pos, 1);
    chk("post_rst_err", err, 0);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
